// File: rtl/hsv_thresh_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hsv_thresh_pkg
//  Description : Shared types, address map and reset thresholds for the
//                HSV ball-classifier configuration controller.
//  Revision    : 1.0  initial release
// ============================================================================
package hsv_thresh_pkg;

    localparam int c_num_classes = 5;

    localparam logic [3:0] c_addr_ctrl       = 4'd0;
    localparam logic [3:0] c_addr_status     = 4'd1;
    localparam logic [3:0] c_addr_class_base = 4'd2;

    localparam int c_ctrl_commit_bit  = 0;
    localparam int c_ctrl_force_bit   = 1;
    localparam int c_ctrl_pending_bit = 2;
    localparam int c_ctrl_en_lsb      = 8;

    // Classifier output codes; bank slot k holds class code k+1.
    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_RED    = 3'd1,
        CLS_YELLOW = 3'd2,
        CLS_GREEN  = 3'd3,
        CLS_BLUE   = 3'd4,
        CLS_PINK   = 3'd5
    } ball_class_e;

    typedef struct packed {
        logic [8:0] h_lo;
        logic [8:0] h_hi;
        logic [7:0] s_min;
        logic [7:0] v_min;
    } class_thresh_t;

    function automatic class_thresh_t default_thresh(input int idx);
        class_thresh_t t;
        t = '0;
        case (idx)
            int'(CLS_RED)    - 1: t = '{h_lo: 9'd359, h_hi: 9'd27,  s_min: 8'd68, v_min: 8'd24};
            int'(CLS_YELLOW) - 1: t = '{h_lo: 9'd68,  h_hi: 9'd79,  s_min: 8'd57, v_min: 8'd65};
            int'(CLS_GREEN)  - 1: t = '{h_lo: 9'd137, h_hi: 9'd170, s_min: 8'd54, v_min: 8'd23};
            int'(CLS_BLUE)   - 1: t = '{h_lo: 9'd187, h_hi: 9'd241, s_min: 8'd35, v_min: 8'd1};
            int'(CLS_PINK)   - 1: t = '{h_lo: 9'd0,   h_hi: 9'd31,  s_min: 8'd30, v_min: 8'd58};
            default:              t = '0;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hsv_thresh_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hsv_thresh_ctrl_if
//  Description : Avalon-MM register port of the HSV threshold controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface hsv_thresh_ctrl_if;
    logic [3:0]  s_address;
    logic        s_write;
    logic [31:0] s_writedata;
    logic        s_read;
    logic [31:0] s_readdata;

    modport master (
        output s_address, s_write, s_writedata, s_read,
        input  s_readdata
    );

    modport slave (
        input  s_address, s_write, s_writedata, s_read,
        output s_readdata
    );
endinterface
`default_nettype wire

// File: rtl/hsv_thresh_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hsv_thresh_ctrl
//  Description : Shadow/active threshold banks for the HSV classifier; the
//                shadow bank is copied to active only at a frame boundary.
//  Revision    : 1.0  initial release
// ============================================================================
module hsv_thresh_ctrl
    import hsv_thresh_pkg::*;
#(
    parameter int NUM_CLASSES = c_num_classes
) (
    input  logic                       clk,
    input  logic                       rst,
    hsv_thresh_ctrl_if.slave           bus,
    input  logic                       in_valid,
    input  logic                       in_ready,
    input  logic                       in_sop,
    output logic [9*NUM_CLASSES-1:0]   cfg_h_lo,
    output logic [9*NUM_CLASSES-1:0]   cfg_h_hi,
    output logic [8*NUM_CLASSES-1:0]   cfg_s_min,
    output logic [8*NUM_CLASSES-1:0]   cfg_v_min,
    output logic [NUM_CLASSES-1:0]     cfg_en,
    output logic                       commit_pending
);

    localparam logic [3:0] c_num_cls_w = 4'(NUM_CLASSES);

    class_thresh_t            r_shadow [NUM_CLASSES];
    class_thresh_t            r_active [NUM_CLASSES];
    logic [NUM_CLASSES-1:0]   r_shadow_en;
    logic [NUM_CLASSES-1:0]   r_active_en;
    logic                     r_pending;
    logic                     r_sop_d1;
    logic [15:0]              r_frames_seen;
    logic [15:0]              r_commits_done;
    logic [31:0]              r_readdata;

    logic [3:0]               w_cls_off;
    logic [2:0]               w_cls_idx;
    logic                     w_is_class;
    logic                     w_ctrl_wr;
    logic                     w_commit_req;
    logic                     w_force;
    logic                     w_sop_acc;
    logic                     w_commit;
    logic [31:0]              w_rdata;

    assign w_cls_off    = bus.s_address - c_addr_class_base;
    assign w_cls_idx    = w_cls_off[3:1];
    assign w_is_class   = (bus.s_address >= c_addr_class_base) &&
                          ({1'b0, w_cls_idx} < c_num_cls_w);
    assign w_ctrl_wr    = bus.s_write && (bus.s_address == c_addr_ctrl);
    assign w_commit_req = w_ctrl_wr && bus.s_writedata[c_ctrl_commit_bit];
    assign w_force      = w_ctrl_wr && bus.s_writedata[c_ctrl_force_bit];
    assign w_sop_acc    = in_valid && in_ready && in_sop;

    // The copy fires on the edge where the delayed sop enters the second
    // stage, i.e. the edge that lands the sop pixel's HSV at the compare.
    assign w_commit     = w_force || (r_sop_d1 && r_pending);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_shadow[k] <= default_thresh(k);
            end
            r_shadow_en <= '1;
        end else begin
            if (w_ctrl_wr) begin
                r_shadow_en <= bus.s_writedata[c_ctrl_en_lsb +: NUM_CLASSES];
            end
            if (bus.s_write && w_is_class) begin
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    if (w_cls_idx == 3'(k)) begin
                        if (!w_cls_off[0]) begin
                            r_shadow[k].h_lo <= bus.s_writedata[8:0];
                            r_shadow[k].h_hi <= bus.s_writedata[24:16];
                        end else begin
                            r_shadow[k].s_min <= bus.s_writedata[7:0];
                            r_shadow[k].v_min <= bus.s_writedata[15:8];
                        end
                    end
                end
            end
        end
    end

    // Copies the pre-edge shadow, so a same-cycle register write stays shadow-only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_active[k] <= default_thresh(k);
            end
            r_active_en <= '1;
        end else if (w_commit) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_active[k] <= r_shadow[k];
            end
            r_active_en <= r_shadow_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending      <= 1'b0;
            r_sop_d1       <= 1'b0;
            r_frames_seen  <= '0;
            r_commits_done <= '0;
        end else begin
            r_sop_d1 <= w_sop_acc;
            if (w_commit_req) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
            if (w_sop_acc) begin
                r_frames_seen <= r_frames_seen + 16'd1;
            end
            if (w_commit) begin
                r_commits_done <= r_commits_done + 16'd1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (bus.s_address == c_addr_ctrl) begin
            w_rdata[c_ctrl_pending_bit]                = r_pending;
            w_rdata[c_ctrl_en_lsb +: NUM_CLASSES]      = r_shadow_en;
        end else if (bus.s_address == c_addr_status) begin
            w_rdata = {r_commits_done, r_frames_seen};
        end else if (w_is_class) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                if (w_cls_idx == 3'(k)) begin
                    if (!w_cls_off[0]) begin
                        w_rdata[8:0]   = r_shadow[k].h_lo;
                        w_rdata[24:16] = r_shadow[k].h_hi;
                    end else begin
                        w_rdata[7:0]   = r_shadow[k].s_min;
                        w_rdata[15:8]  = r_shadow[k].v_min;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_readdata <= '0;
        end else if (bus.s_read) begin
            r_readdata <= w_rdata;
        end
    end

    assign bus.s_readdata  = r_readdata;
    assign commit_pending  = r_pending;
    assign cfg_en          = r_active_en;

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cfg
        assign cfg_h_lo[9*k +: 9]  = r_active[k].h_lo;
        assign cfg_h_hi[9*k +: 9]  = r_active[k].h_hi;
        assign cfg_s_min[8*k +: 8] = r_active[k].s_min;
        assign cfg_v_min[8*k +: 8] = r_active[k].v_min;
    end

endmodule
`default_nettype wire

// File: tb/tb_hsv_thresh_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hsv_thresh_ctrl
//  Description : Directed scoreboard bench for hsv_thresh_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hsv_thresh_ctrl;

    localparam int N = 5;

    localparam int K_HLO   = 0;
    localparam int K_HHI   = 1;
    localparam int K_SMIN  = 2;
    localparam int K_VMIN  = 3;
    localparam int K_EN    = 4;
    localparam int K_PEND  = 5;
    localparam int K_RDATA = 6;

    typedef struct {
        string       name;
        int          kind;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready = 1'b0;
    logic             in_sop = 1'b0;
    logic [9*N-1:0]   cfg_h_lo;
    logic [9*N-1:0]   cfg_h_hi;
    logic [8*N-1:0]   cfg_s_min;
    logic [8*N-1:0]   cfg_v_min;
    logic [N-1:0]     cfg_en;
    logic             commit_pending;
    logic             rd_dly = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    chk_t cfg_q[$];
    chk_t rd_q[$];

    hsv_thresh_ctrl_if bus ();

    hsv_thresh_ctrl #(.NUM_CLASSES(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sop         (in_sop),
        .cfg_h_lo       (cfg_h_lo),
        .cfg_h_hi       (cfg_h_hi),
        .cfg_s_min      (cfg_s_min),
        .cfg_v_min      (cfg_v_min),
        .cfg_en         (cfg_en),
        .commit_pending (commit_pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_dly <= bus.s_read;

    function automatic logic [31:0] get_actual(input int kind, input int sel);
        case (kind)
            K_HLO:   return 32'(cfg_h_lo[9*sel +: 9]);
            K_HHI:   return 32'(cfg_h_hi[9*sel +: 9]);
            K_SMIN:  return 32'(cfg_s_min[8*sel +: 8]);
            K_VMIN:  return 32'(cfg_v_min[8*sel +: 8]);
            K_EN:    return 32'(cfg_en);
            K_PEND:  return 32'(commit_pending);
            default: return bus.s_readdata;
        endcase
    endfunction

    task automatic compare(input chk_t c, input logic [31:0] act);
        tests_run++;
        if (act !== c.exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
        end
    endtask

    // Monitor: output snapshots are checked mid-cycle; read data one edge after s_read.
    always @(negedge clk) begin
        chk_t c;
        while (cfg_q.size() > 0) begin
            c = cfg_q.pop_front();
            compare(c, get_actual(c.kind, c.sel));
        end
        if (rd_dly) begin
            if (rd_q.size() > 0) begin
                c = rd_q.pop_front();
                compare(c, bus.s_readdata);
            end else begin
                tests_run++;
                tests_failed++;
                $display("FAIL rd_unexpected: got 0x%08h expected no read", bus.s_readdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int kind, input int sel, input logic [31:0] e);
        chk_t c;
        c.name = nm; c.kind = kind; c.sel = sel; c.exp = e;
        cfg_q.push_back(c);
    endtask

    task automatic exp_cls(input string nm, input int sel, input int hl, input int hh,
                           input int s, input int v);
        chk({nm, "_hlo"}, K_HLO, sel, 32'(hl));
        chk({nm, "_hhi"}, K_HHI, sel, 32'(hh));
        chk({nm, "_smin"}, K_SMIN, sel, 32'(s));
        chk({nm, "_vmin"}, K_VMIN, sel, 32'(v));
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.s_address = a; bus.s_writedata = d; bus.s_write = 1'b1;
        tick();
        bus.s_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
        chk_t c;
        c.name = nm; c.kind = K_RDATA; c.sel = 0; c.exp = e;
        rd_q.push_back(c);
        bus.s_address = a; bus.s_read = 1'b1;
        tick();
        bus.s_read = 1'b0;
    endtask

    task automatic stream(input logic v);
        in_valid = v; in_ready = v; in_sop = v;
    endtask

    task automatic sop_beat();
        stream(1'b1);
        tick();
        stream(1'b0);
    endtask

    task automatic exp_defaults(input string nm);
        exp_cls({nm, "_red"},    0, 359, 27,  68, 24);
        exp_cls({nm, "_yellow"}, 1, 68,  79,  57, 65);
        exp_cls({nm, "_green"},  2, 137, 170, 54, 23);
        exp_cls({nm, "_blue"},   3, 187, 241, 35, 1);
        exp_cls({nm, "_pink"},   4, 0,   31,  30, 58);
        chk({nm, "_en"}, K_EN, 0, 32'h1F);
        chk({nm, "_pend"}, K_PEND, 0, 32'h0);
    endtask

    initial begin
        bus.s_address = '0; bus.s_write = 1'b0; bus.s_writedata = '0; bus.s_read = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state and register read-back.
        chk("rst_readdata", K_RDATA, 0, 32'h0);
        exp_defaults("rst");
        rd(4'd2,  32'h001B_0167, "rd_red_h");
        rd(4'd0,  32'h0000_1F00, "rd_ctrl");
        rd(4'd7,  32'h0000_1736, "rd_green_sv");
        rd(4'd10, 32'h001F_0000, "rd_pink_h");
        rd(4'd1,  32'h0000_0000, "rd_status_rst");
        wr(4'd13, 32'hFFFF_FFFF);
        rd(4'd13, 32'h0000_0000, "rd_unmapped");

        // Shadow write without COMMIT across three frames.
        wr(4'd8, 32'h00F0_00A0);
        repeat (3) begin
            sop_beat();
            tick();
        end
        exp_cls("blue_nocommit", 3, 187, 241, 35, 1);
        chk("nocommit_pend", K_PEND, 0, 32'h0);
        rd(4'd8, 32'h00F0_00A0, "rd_blue_shadow");
        rd(4'd1, 32'h0000_0003, "rd_status_3frames");

        // COMMIT aligned to the frame boundary.
        wr(4'd6, 32'h00A0_0080);
        wr(4'd0, 32'h0000_1F01);
        chk("commit_pend_set", K_PEND, 0, 32'h1);
        rd(4'd0, 32'h0000_1F04, "rd_ctrl_pending");
        stream(1'b1);
        chk("green_T_hlo", K_HLO, 2, 32'd137);
        tick();
        stream(1'b0);
        chk("green_T1_hlo", K_HLO, 2, 32'd137);
        chk("green_T1_hhi", K_HHI, 2, 32'd170);
        chk("green_T1_pend", K_PEND, 0, 32'h1);
        tick();
        chk("green_T2_hlo", K_HLO, 2, 32'd128);
        chk("green_T2_hhi", K_HHI, 2, 32'd160);
        chk("blue_T2_hlo", K_HLO, 3, 32'd160);
        chk("blue_T2_hhi", K_HHI, 3, 32'd240);
        chk("green_T2_pend", K_PEND, 0, 32'h0);
        rd(4'd1, 32'h0001_0004, "rd_status_commit");

        // FORCE with the stream idle.
        wr(4'd5, 32'h0000_4A3C);
        wr(4'd0, 32'h0000_1F01);
        chk("force_pre_pend", K_PEND, 0, 32'h1);
        chk("force_pre_smin", K_SMIN, 1, 32'd57);
        wr(4'd0, 32'h0000_1F02);
        chk("force_smin", K_SMIN, 1, 32'd60);
        chk("force_vmin", K_VMIN, 1, 32'd74);
        chk("force_pend", K_PEND, 0, 32'h0);

        // Shadow write and COMMIT in the commit cycle itself.
        wr(4'd2, 32'h0014_0150);
        wr(4'd0, 32'h0000_1F01);
        stream(1'b1);
        tick();
        stream(1'b0);
        wr(4'd0, 32'h0000_0F01);
        chk("coinc_red_hlo", K_HLO, 0, 32'd336);
        chk("coinc_red_hhi", K_HHI, 0, 32'd20);
        chk("coinc_en_old", K_EN, 0, 32'h1F);
        chk("coinc_pend", K_PEND, 0, 32'h1);
        rd(4'd0, 32'h0000_0F04, "rd_ctrl_coinc");
        sop_beat();
        tick();
        chk("coinc_next_en", K_EN, 0, 32'h0F);
        chk("coinc_next_pend", K_PEND, 0, 32'h0);

        // Reset mid-frame with a commit pending and a sop in flight.
        wr(4'd7, 32'h0010_2030);
        wr(4'd0, 32'h0000_0F01);
        chk("pre_rst_pend", K_PEND, 0, 32'h1);
        stream(1'b1);
        tick();
        stream(1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_readdata", K_RDATA, 0, 32'h0);
        exp_defaults("mid_rst");
        rd(4'd1, 32'h0000_0000, "rd_status_after_rst");
        rd(4'd0, 32'h0000_1F00, "rd_ctrl_after_rst");
        rd(4'd7, 32'h0000_1736, "rd_green_sv_after_rst");
        sop_beat();
        tick();
        tick();
        chk("post_rst_green_smin", K_SMIN, 2, 32'd54);
        chk("post_rst_en", K_EN, 0, 32'h1F);
        rd(4'd1, 32'h0000_0001, "rd_status_post_rst");

        tick();
        tick();
        tests_run++;
        if (cfg_q.size() != 0 || rd_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0",
                     cfg_q.size() + rd_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
